// File: rtl/tri_pkg.sv
// Shared sizes, types and helpers for the triangle raster frame buffer.
//   CW   : coordinate width; the bitmap is DIM x DIM with DIM = 2**CW.
//   CNTW : width of the pixel/duplicate counters (covers 0..DIM*DIM).
package tri_pkg;

    localparam int unsigned CW   = 3;
    localparam int unsigned DIM  = 1 << CW;
    localparam int unsigned CNTW = 2 * CW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDrain
    } state_e;

    typedef logic [CW-1:0]   coord_t;
    typedef logic [DIM-1:0]  row_t;
    typedef logic [CNTW-1:0] cnt_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic cnt_t sat_inc(cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/tri_fb_bitmap.sv
// DIM x DIM single-bit pixel store.
//   clk_i, rst_i : clock and synchronous active-high reset (clears all bits)
//   clr_i        : synchronous clear-all; wins over set_i
//   set_i        : set pixel (x_i, y_i) on the next edge
//   x_i, y_i     : coordinate for set and for the combinational test read bit_o
//   rd_row_i     : row index for the combinational row read row_o
module tri_fb_bitmap
    import tri_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   clr_i,
    input  logic   set_i,
    input  coord_t x_i,
    input  coord_t y_i,
    output logic   bit_o,
    input  coord_t rd_row_i,
    output row_t   row_o
);

    row_t bits_q [DIM];

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            bits_q <= '{default: '0};
        end else if (set_i) begin
            bits_q[y_i][x_i] <= 1'b1;
        end
    end

    assign bit_o = bits_q[y_i][x_i];
    assign row_o = bits_q[rd_row_i];

endmodule

// File: rtl/tri_raster_fb.sv
// Frame buffer behind the triangle engine: captures engine points into a bitmap while
// the engine is busy, then streams the bitmap out row by row over valid/ready and
// clears it for the next triangle.
//   clk, reset          : clock, synchronous active-high reset
//   busy, po, xo, yo    : engine busy flag and point strobe/coordinates
//   row_valid/row_ready : row stream handshake; row_idx/row_data carry the row
//   frame_done          : one-cycle pulse after the last row is accepted
//   pix_cnt, dup_cnt    : distinct pixels / repeated hits of the current or last frame
//   ovf                 : sticky flag, a point arrived while draining
module tri_raster_fb
    import tri_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            busy,
    input  logic            po,
    input  logic [CW-1:0]   xo,
    input  logic [CW-1:0]   yo,
    output logic            row_valid,
    input  logic            row_ready,
    output logic [CW-1:0]   row_idx,
    output logic [DIM-1:0]  row_data,
    output logic            frame_done,
    output logic [CNTW-1:0] pix_cnt,
    output logic [CNTW-1:0] dup_cnt,
    output logic            ovf
);

    state_e state_q, state_d;
    logic   busy_q;
    cnt_t   pix_q, pix_d;
    cnt_t   dup_q, dup_d;
    coord_t row_idx_q, row_idx_d;
    logic   frame_done_q, frame_done_d;
    logic   ovf_q, ovf_d;

    logic   set_en, clr_en, hit_bit;
    row_t   rd_row;
    logic   busy_fall;

    assign busy_fall = busy_q & ~busy;

    tri_fb_bitmap u_bitmap (
        .clk_i    (clk),
        .rst_i    (reset),
        .clr_i    (clr_en),
        .set_i    (set_en),
        .x_i      (xo),
        .y_i      (yo),
        .bit_o    (hit_bit),
        .rd_row_i (row_idx_q),
        .row_o    (rd_row)
    );

    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        dup_d        = dup_q;
        row_idx_d    = row_idx_q;
        frame_done_d = 1'b0;
        ovf_d        = ovf_q;
        set_en       = 1'b0;
        clr_en       = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Counters restart only here so the last frame's counts stay readable.
                if (busy || po) begin
                    state_d = StCapture;
                    set_en  = po;
                    pix_d   = (po && !hit_bit) ? cnt_t'(1) : '0;
                    dup_d   = (po &&  hit_bit) ? cnt_t'(1) : '0;
                end
            end
            StCapture: begin
                if (po) begin
                    set_en = 1'b1;
                    if (hit_bit) dup_d = sat_inc(dup_q);
                    else         pix_d = pix_q + cnt_t'(1);
                end
                if (busy_fall) state_d = StDrain;
            end
            StDrain: begin
                if (po) ovf_d = 1'b1;
                if (row_ready) begin
                    row_idx_d = row_idx_q + coord_t'(1);
                    if (row_idx_q == coord_t'(DIM - 1)) begin
                        clr_en       = 1'b1;
                        frame_done_d = 1'b1;
                        state_d      = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            pix_q        <= '0;
            dup_q        <= '0;
            row_idx_q    <= '0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy;
            pix_q        <= pix_d;
            dup_q        <= dup_d;
            row_idx_q    <= row_idx_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign row_valid  = (state_q == StDrain);
    assign row_idx    = row_idx_q;
    // Outside DRAIN the row bus is quiet rather than showing a half-built frame.
    assign row_data   = row_valid ? rd_row : '0;
    assign frame_done = frame_done_q;
    assign pix_cnt    = pix_q;
    assign dup_cnt    = dup_q;
    assign ovf        = ovf_q;

endmodule

// File: doc/tri_raster_fb.md
Name: tri_raster_fb

Overview:
Downstream consumer of the triangle rendering engine. Captures each rendered point (po/xo/yo) into an on-chip 2^CW x 2^CW bitmap while the engine is busy. When the triangle completes, it drains the bitmap row by row over a valid/ready stream. The bitmap is then cleared for the next triangle. The output feeds the display/readback path.

Parameters:
CW, 3, coordinate width; bitmap is DIM x DIM with DIM = 2^CW (8 by default).
CNTW, 2*CW+1, width of the pixel and duplicate counters (7 by default, covering 0..64).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
busy  in  1  engine busy, sampled each cycle.
po  in  1  engine point-valid strobe.
xo  in  CW  point x coordinate, valid when po=1.
yo  in  CW  point y coordinate, valid when po=1.
row_valid  out  1  row_data/row_idx valid.
row_ready  in  1  downstream accepts the row when row_valid & row_ready.
row_idx  out  CW  row number (y) being presented.
row_data  out  DIM  row_data[x] = pixel (x, row_idx).
frame_done  out  1  one-cycle pulse after the last row is accepted.
pix_cnt  out  CNTW  distinct pixels set in the current/last frame.
dup_cnt  out  CNTW  po hits on pixels already set (saturates at max).
ovf  out  1  sticky; set when po=1 arrives in DRAIN; cleared only by reset.

Behaviour:
- Reset (sync, active-high, overrides all): state=IDLE; bitmap all 0; row_valid=0; row_idx=0; row_data=0; frame_done=0; pix_cnt=0; dup_cnt=0; ovf=0. Reset asserted mid-CAPTURE or mid-DRAIN aborts the frame with no frame_done.
- busy_q is a registered copy of busy. Falling edge: busy_q=1 & busy=0.
- IDLE:
  - On busy=1 or po=1, go to CAPTURE.
  - pix_cnt and dup_cnt are zeroed on entry to CAPTURE, not before, so the last frame's counts stay readable in IDLE.
  - A po=1 in the entry cycle is captured.
- CAPTURE:
  - For each cycle with po=1, set bitmap[yo][xo] on the next edge.
  - If the bit was 0, pix_cnt += 1; otherwise dup_cnt += 1 (saturating).
  - On a busy falling edge, go to DRAIN. A po=1 in that same cycle is still captured.
- DRAIN:
  - row_valid=1 with row_idx starting at 0; row_data is combinational from bitmap[row_idx].
  - While row_valid & !row_ready, row_idx and row_data are held stable.
  - On accept, row_idx += 1. Back-to-back accepts give 1 row per cycle, so the minimum drain is DIM cycles.
  - On accept of row DIM-1: row_valid=0 and frame_done=1 next cycle; the bitmap is cleared in that same edge (single-cycle clear); row_idx wraps to 0; state returns to IDLE.
- po=1 during DRAIN: the point is ignored (bitmap and counts unchanged) and ovf is set.
- busy rising during DRAIN: no effect until IDLE; the engine holds busy high through a triangle, so the next CAPTURE starts from IDLE.
- A frame with zero points drains DIM all-zero rows and reports pix_cnt=0.
- Latency:
  - busy falling edge at cycle N → first row_valid at cycle N+1.
  - Last accept at cycle M → frame_done at cycle M+1 → IDLE at cycle M+1.

Decomposition:
- Package tri_pkg:
  - CW and DIM constants.
  - State enum {IDLE, CAPTURE, DRAIN}.
  - Typedefs for coordinate (CW bits), row (DIM bits) and count (CNTW bits).
- Sub-module tri_fb_bitmap:
  - DIM x DIM flop array with synchronous set(x,y).
  - Combinational test-bit read of (x,y).
  - Combinational row read by index.
  - Synchronous clear-all (clear has priority over set).
- Top level holds the FSM, busy edge detect, counters and handshake.

Test Plan:
- Points (0,0),(1,0),(1,1) with busy high, then busy falls; row_ready=1 → rows 0..7 = 0x03,0x02,0x00×6 in consecutive cycles; pix_cnt=3; dup_cnt=0; frame_done one cycle after row 7.
- Duplicates: (3,3) sent 3 times → pix_cnt=1, dup_cnt=2, row 3 = 0x08.
- Backpressure: row_ready low for 4 cycles on row 2 → row_idx=2 and row_data held stable; drain resumes at row 3; no row skipped or repeated.
- Edge timing: po=1 (7,7) in the same cycle busy falls → captured; row 7 = 0x80; pix_cnt=1.
- po=1 during DRAIN → ovf=1 and bitmap unchanged; a second frame after frame_done starts from an all-zero bitmap with pix_cnt reset at CAPTURE entry; ovf stays 1 until reset.
- Reset asserted at row 4 of a drain → all outputs at reset values next cycle; no frame_done; next frame correct.
